writeback_unit: RTL and testbench

Write-back stage and scoreboard for the RV32 core; the producer side of the register-file write port. It merges single-cycle ALU results and variable-latency load returns into one registered write per cycle (`we`, `rd_addr`, `rd_din`). It tracks a busy bit per architectural register and gates instruction issue on RAW and WAW hazards. It sits between the execute/memory stages and the register file, and back-pressures decode through `issue_ready`.

---
 rtl/writeback_unit.sv | 155 +++++++++++++++
 tb/tb_writeback_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Write-back stage: merges ALU results and buffered load returns into one
// registered register-file write per cycle, with a per-register busy scoreboard.
module writeback_unit #(
  parameter int unsigned MEM_FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_has_rd,
  output logic        issue_ready,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_din,
  output logic        idle,
  output logic        wb_err
);

  localparam int unsigned AW = $clog2(MEM_FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_t;

  ld_t           fifo_q [MEM_FIFO_DEPTH];
  ld_t           head;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0]   busy_q, busy_d;
  logic          we_q, we_d;
  logic [4:0]    addr_q, addr_d;
  logic [31:0]   din_q, din_d;
  logic          err_q, err_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          issue_fire;
  logic          sel_valid;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(MEM_FIFO_DEPTH));
  assign head       = fifo_q[rptr_q];

  assign mem_ready  = !fifo_full;
  assign push       = mem_valid & mem_ready;
  assign pop        = !alu_valid & !fifo_empty;

  assign issue_ready = !busy_q[issue_rs1]
                     & !busy_q[issue_rs2]
                     & !(issue_has_rd & busy_q[issue_rd]);
  assign issue_fire  = issue_valid & issue_ready;

  // ALU results are never buffered, so they always win the write port.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    priority case (1'b1)
      alu_valid: begin
        sel_valid = 1'b1;
        sel_rd    = alu_rd;
        sel_data  = alu_data;
      end
      !fifo_empty: begin
        sel_valid = 1'b1;
        sel_rd    = head.rd;
        sel_data  = head.data;
      end
      default: ;
    endcase
  end

  always_comb begin
    we_d   = sel_valid & (sel_rd != 5'd0);
    addr_d = addr_q;
    din_d  = din_q;
    err_d  = err_q;
    if (we_d) begin
      addr_d = sel_rd;
      din_d  = sel_data;
      if (!busy_q[sel_rd]) err_d = 1'b1;
    end
  end

  // Clear follows the registered write; set only hits a non-busy register.
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[addr_q] = 1'b0;
    if (issue_fire && issue_has_rd) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push) wptr_d = wptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= '{rd: mem_rd, data: mem_data};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      busy_q <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      err_q  <= err_d;
    end
  end

  assign we      = we_q;
  assign rd_addr = addr_q;
  assign rd_din  = din_q;
  assign wb_err  = err_q;
  assign idle    = (busy_q == '0) & fifo_empty & !we_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: vector table, hand sequences for FIFO-full and
// reset, then random traffic against a queue-based reference model.
module tb_writeback_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_has_rd;
  logic        issue_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_din;
  logic        idle;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_unit #(.MEM_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_has_rd(issue_has_rd), .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_ready(mem_ready),
    .we(we), .rd_addr(rd_addr), .rd_din(rd_din),
    .idle(idle), .wb_err(wb_err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic clr_in();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0;
    issue_rd = 0; issue_has_rd = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    rstn = 0;
    repeat (2) @(posedge clk);
    #3 rstn = 1;
    tick();
  endtask

  task automatic issue(input logic [4:0] r);
    issue_valid = 1; issue_rd = r; issue_has_rd = 1;
    tick();
    clr_in();
  endtask

  typedef struct {
    logic        iv;
    logic [4:0]  rs1, rs2, rd;
    logic        hrd;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        ir, mr;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic        cd;
    logic        err, idle;
  } vec_t;

  vec_t vt [17];

  // Reference model state
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  logic [31:0] mb;
  ent_t        mq [$];
  logic        ewe;
  logic [4:0]  eaddr;
  logic [31:0] edin;
  logic        eerr;

  function automatic logic m_ir();
    return !mb[issue_rs1] && !mb[issue_rs2] && !(issue_has_rd && mb[issue_rd]);
  endfunction

  function automatic logic m_mr();
    return mq.size() < DEPTH;
  endfunction

  task automatic m_reset();
    mb = 0; mq.delete(); ewe = 0; eaddr = 0; edin = 0; eerr = 0;
  endtask

  task automatic m_step(input logic irx, input logic mrx);
    logic        has;
    logic [4:0]  srd;
    logic [31:0] sd;
    logic [31:0] nb;
    ent_t        e;
    has = 0; srd = 0; sd = 0;
    if (alu_valid) begin
      has = 1; srd = alu_rd; sd = alu_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      has = 1; srd = e.rd; sd = e.d;
    end
    if (mem_valid && mrx) mq.push_back('{rd: mem_rd, d: mem_data});
    nb = mb;
    if (ewe) nb[eaddr] = 0;
    if (issue_valid && irx && issue_has_rd && issue_rd != 0)
      nb[issue_rd] = 1;
    ewe = has && srd != 0;
    if (ewe) begin
      if (!mb[srd]) eerr = 1;
      eaddr = srd; edin = sd;
    end
    mb = nb;
  endtask

  function automatic logic [4:0] pick();
    int r;
    r = $urandom_range(0, 31);
    if ($urandom_range(0, 9) < 8)
      for (int k = 0; k < 32; k++)
        if (mb[(r + k) % 32]) return 5'((r + k) % 32);
    return 5'(r);
  endfunction

  initial begin
    clr_in();
    rstn = 0;

    // Reset state
    #2;
    chk("rst_we", we, 0);
    chk("rst_idle", idle, 1);
    chk("rst_mem_ready", mem_ready, 1);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_err", wb_err, 0);
    do_reset();

    // Fields: iv rs1 rs2 rd hrd | av ard adat | mv mrd mdat |
    //         ir mr | we addr din cd | err idle
    vt[0]  = '{1,0,0,5,1,  0,0,0,             0,0,0,     1,1, 0,0,0,1,             0,0};
    vt[1]  = '{0,0,0,0,0,  1,5,'hDEADBEEF,    0,0,0,     1,1, 1,5,'hDEADBEEF,1,    0,0};
    vt[2]  = '{1,5,0,0,0,  0,0,0,             0,0,0,     0,1, 0,5,'hDEADBEEF,1,    0,1};
    vt[3]  = '{1,5,0,0,0,  0,0,0,             0,0,0,     1,1, 0,5,'hDEADBEEF,1,    0,1};
    vt[4]  = '{1,0,0,3,1,  0,0,0,             0,0,0,     1,1, 0,5,'hDEADBEEF,1,    0,0};
    vt[5]  = '{1,0,0,4,1,  0,0,0,             0,0,0,     1,1, 0,5,'hDEADBEEF,1,    0,0};
    vt[6]  = '{0,0,0,0,0,  1,4,'h22,          1,3,'h11,  1,1, 1,4,'h22,1,          0,0};
    vt[7]  = '{0,0,0,0,0,  0,0,0,             0,0,0,     1,1, 1,3,'h11,1,          0,0};
    vt[8]  = '{0,0,0,0,0,  0,0,0,             0,0,0,     1,1, 0,3,'h11,1,          0,1};
    vt[9]  = '{0,0,0,0,0,  1,0,'h55,          0,0,0,     1,1, 0,0,0,0,             0,1};
    vt[10] = '{0,0,0,0,0,  1,9,'h99,          0,0,0,     1,1, 1,9,'h99,1,          1,0};
    vt[11] = '{0,0,0,0,0,  0,0,0,             0,0,0,     1,1, 0,9,'h99,1,          1,1};
    vt[12] = '{0,0,0,0,0,  0,0,0,             0,0,0,     1,1, 0,9,'h99,1,          1,1};
    vt[13] = '{1,0,0,10,1, 0,0,0,             0,0,0,     1,1, 0,9,'h99,1,          1,0};
    vt[14] = '{1,0,10,0,0, 0,0,0,             0,0,0,     0,1, 0,9,'h99,1,          1,0};
    vt[15] = '{1,0,0,10,1, 0,0,0,             0,0,0,     0,1, 0,9,'h99,1,          1,0};
    vt[16] = '{1,0,0,10,0, 0,0,0,             0,0,0,     1,1, 0,9,'h99,1,          1,0};

    for (int i = 0; i < 17; i++) begin
      issue_valid = vt[i].iv; issue_rs1 = vt[i].rs1;
      issue_rs2 = vt[i].rs2; issue_rd = vt[i].rd;
      issue_has_rd = vt[i].hrd;
      alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].adat;
      mem_valid = vt[i].mv; mem_rd = vt[i].mrd; mem_data = vt[i].mdat;
      #1;
      chk($sformatf("v%0d_issue_ready", i), issue_ready, vt[i].ir);
      chk($sformatf("v%0d_mem_ready", i), mem_ready, vt[i].mr);
      tick();
      chk($sformatf("v%0d_we", i), we, vt[i].we);
      if (vt[i].cd) begin
        chk($sformatf("v%0d_rd_addr", i), rd_addr, vt[i].addr);
        chk($sformatf("v%0d_rd_din", i), rd_din, vt[i].din);
      end
      chk($sformatf("v%0d_wb_err", i), wb_err, vt[i].err);
      chk($sformatf("v%0d_idle", i), idle, vt[i].idle);
    end

    // FIFO full: four back-to-back ALU writes starve three load returns
    do_reset();
    issue(1); issue(2); issue(3);
    issue(11); issue(12); issue(13); issue(14);
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 5'(11 + i); alu_data = 32'hB0 + i;
      if (i < 2) begin
        mem_valid = 1; mem_rd = 5'(1 + i); mem_data = 32'hA1 + i;
      end else begin
        mem_valid = 1; mem_rd = 3; mem_data = 32'hA3;
      end
      #1;
      chk($sformatf("full_mem_ready_%0d", i), mem_ready, i < 2);
      tick();
      chk($sformatf("full_alu_we_%0d", i), we, 1);
      chk($sformatf("full_alu_addr_%0d", i), rd_addr, 11 + i);
    end
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    #1;
    chk("full_held_ready", mem_ready, 0);
    tick();
    chk("full_pop1_addr", rd_addr, 1);
    chk("full_pop1_din", rd_din, 32'hA1);
    chk("full_freed_ready", mem_ready, 1);
    tick();
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    chk("full_pop2_addr", rd_addr, 2);
    chk("full_pop2_din", rd_din, 32'hA2);
    tick();
    chk("full_pop3_we", we, 1);
    chk("full_pop3_addr", rd_addr, 3);
    chk("full_pop3_din", rd_din, 32'hA3);
    tick();
    chk("full_drain_we", we, 0);
    chk("full_drain_idle", idle, 1);
    chk("full_drain_err", wb_err, 0);

    // Reset while writing, busy bits set, FIFO full and error latched
    alu_valid = 1; alu_rd = 9; alu_data = 32'h9;
    tick();
    clr_in();
    chk("mid_err_set", wb_err, 1);
    issue(1); issue(2); issue(4);
    alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
    mem_valid = 1; mem_rd = 1; mem_data = 32'hC1;
    tick();
    alu_data = 32'h45;
    mem_rd = 2; mem_data = 32'hC2;
    tick();
    clr_in();
    issue_valid = 1; issue_rs1 = 1; issue_rs2 = 2;
    issue_rd = 1; issue_has_rd = 1;
    chk("mid_pre_we", we, 1);
    chk("mid_pre_full", mem_ready, 0);
    #2 rstn = 0;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_mem_ready", mem_ready, 1);
    chk("mid_rst_issue_ready", issue_ready, 1);
    chk("mid_rst_err", wb_err, 0);
    chk("mid_rst_addr", rd_addr, 0);
    chk("mid_rst_din", rd_din, 0);
    clr_in();
    @(posedge clk);
    #3 rstn = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst_we_%0d", i), we, 0);
      chk($sformatf("post_rst_idle_%0d", i), idle, 1);
    end

    // Random traffic against the reference model
    do_reset();
    m_reset();
    begin
      logic hold;
      logic irx, mrx;
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
        issue_valid  = $urandom_range(0, 1);
        issue_rs1    = 5'($urandom_range(0, 31));
        issue_rs2    = 5'($urandom_range(0, 31));
        issue_rd     = 5'($urandom_range(0, 31));
        issue_has_rd = $urandom_range(0, 9) < 7;
        alu_valid    = $urandom_range(0, 9) < 4;
        alu_rd       = pick();
        alu_data     = $urandom;
        if (!hold) begin
          mem_valid = $urandom_range(0, 9) < 3;
          mem_rd    = pick();
          mem_data  = $urandom;
        end
        #1;
        irx = m_ir();
        mrx = m_mr();
        chk("rnd_issue_ready", issue_ready, irx);
        chk("rnd_mem_ready", mem_ready, mrx);
        hold = mem_valid && !mrx;
        m_step(irx, mrx);
        tick();
        chk("rnd_we", we, ewe);
        if (ewe) begin
          chk("rnd_rd_addr", rd_addr, eaddr);
          chk("rnd_rd_din", rd_din, edin);
        end
        chk("rnd_wb_err", wb_err, eerr);
        chk("rnd_idle", idle, mb == 0 && mq.size() == 0 && !ewe);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
